// File: rtl/fpdiv.sv
// fpdiv: sequential floating-point divider, p_out = x_in / y_in.
// Word format: {sign, P-bit biased exponent, (Q-1)-bit fraction}; an exponent
// field of zero is treated as zero (subnormals flush), all-ones as invalid.
// The significand quotient comes from a restoring shift-subtract engine that
// retires one quotient bit per clock (Q+1 bits: Q result bits plus a guard bit).
// A request accepted at edge k has its result presented after edge k+Q+2.
//
// Ports:
//   clk_in    - clock, rising edge
//   rst_in    - synchronous active-high reset
//   x_in      - dividend word
//   y_in      - divisor word
//   round_in  - 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
//   start_in  - request, taken only while ready_out=1
//   p_out     - quotient word, held until the next result
//   oor_out   - [0] overflow [1] underflow [2] divide-by-zero [3] invalid
//   valid_out - one-cycle pulse when p_out/oor_out are new
//   ready_out - idle and able to accept start_in
module fpdiv #(
  parameter int P = 8,
  parameter int Q = 8
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic [P+Q-1:0] x_in,
  input  logic [P+Q-1:0] y_in,
  input  logic [1:0]     round_in,
  input  logic           start_in,
  output logic [P+Q-1:0] p_out,
  output logic [3:0]     oor_out,
  output logic           valid_out,
  output logic           ready_out
);

  localparam int W  = P + Q;
  localparam int F  = Q - 1;
  localparam int CW = $clog2(Q + 2);

  localparam logic signed [P+1:0] BIAS   = (P+2)'((1 << (P - 1)) - 1);
  localparam logic signed [P+1:0] E_MAX  = (P+2)'((1 << P) - 1);
  localparam logic signed [P+1:0] E_ZERO = (P+2)'(0);
  localparam logic signed [P+1:0] E_ONE  = (P+2)'(1);

  // Operand classification captured at accept time
  localparam logic [1:0] K_NORM = 2'd0;
  localparam logic [1:0] K_INV  = 2'd1;
  localparam logic [1:0] K_DBZ  = 2'd2;
  localparam logic [1:0] K_ZERO = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic                 sign_r;
  logic [1:0]           kind_r;
  logic [1:0]           mode_r;
  logic signed [P+1:0]  exp_r;
  logic [Q+1:0]         rem_r;
  logic [Q-1:0]         div_r;
  logic [Q:0]           quo_r;
  logic [CW-1:0]        cnt_r;
  logic [W-1:0]         p_r;
  logic [3:0]           oor_r;
  logic                 valid_r;
  logic                 ready_r;

  // Input decode
  logic [P-1:0]        ex_s, ey_s;
  logic [Q-1:0]        mx_s, my_s;
  logic                x_zero_s, y_zero_s, x_ones_s, y_ones_s;
  logic [1:0]          kind_s;
  logic signed [P+1:0] e_raw_s;

  assign ex_s     = x_in[W-2:F];
  assign ey_s     = y_in[W-2:F];
  assign mx_s     = {1'b1, x_in[F-1:0]};
  assign my_s     = {1'b1, y_in[F-1:0]};
  assign x_zero_s = (ex_s == {P{1'b0}});
  assign y_zero_s = (ey_s == {P{1'b0}});
  assign x_ones_s = &ex_s;
  assign y_ones_s = &ey_s;
  assign e_raw_s  = $signed({2'b00, ex_s}) - $signed({2'b00, ey_s}) + BIAS;

  // Classify the operand pair; invalid takes precedence over divide-by-zero
  always_comb begin
    kind_s = K_NORM;
    if (x_ones_s || y_ones_s || (x_zero_s && y_zero_s)) begin
      kind_s = K_INV;
    end else if (y_zero_s) begin
      kind_s = K_DBZ;
    end else if (x_zero_s) begin
      kind_s = K_ZERO;
    end else begin
      kind_s = K_NORM;
    end
  end

  // One restoring iteration: conditional subtract, then shift the remainder.
  // The remainder stays below twice the divisor, so Q+2 bits never overflow.
  logic         qbit_s;
  logic [Q+1:0] sel_s;
  logic [Q+1:0] rem_nxt_s;

  always_comb begin
    qbit_s    = 1'b0;
    sel_s     = rem_r;
    if (rem_r >= {2'b00, div_r}) begin
      qbit_s = 1'b1;
      sel_s  = rem_r - {2'b00, div_r};
    end else begin
      qbit_s = 1'b0;
      sel_s  = rem_r;
    end
    rem_nxt_s = sel_s << 1;
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    if (start_in) state_nxt_s = DIV;   else state_nxt_s = IDLE;
      DIV:     if (cnt_r == CW'(1)) state_nxt_s = ROUND; else state_nxt_s = DIV;
      ROUND:   state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Result formation: round, normalize a carry-out, range-check, special cases
  logic                g_s, st_s, lsb_s, inc_s;
  logic [Q:0]          sum_s;
  logic [F-1:0]        frac_s;
  logic signed [P+1:0] e_fin_s;
  logic [W-1:0]        max_s, zero_s;
  logic [W-1:0]        p_nxt_s;
  logic [3:0]          oor_nxt_s;

  always_comb begin
    g_s   = quo_r[0];
    st_s  = |rem_r;
    lsb_s = quo_r[1];
    case (mode_r)
      2'b00:   inc_s = g_s & (st_s | lsb_s);
      2'b01:   inc_s = 1'b0;
      2'b10:   inc_s = ~sign_r & (g_s | st_s);
      2'b11:   inc_s = sign_r & (g_s | st_s);
      default: inc_s = 1'b0;
    endcase
    sum_s = {1'b0, quo_r[Q:1]} + {{Q{1'b0}}, inc_s};
    // Significand rounded up to 2.0: shift right and bump the exponent
    if (sum_s[Q]) begin
      frac_s  = sum_s[Q-1:1];
      e_fin_s = exp_r + E_ONE;
    end else begin
      frac_s  = sum_s[F-1:0];
      e_fin_s = exp_r;
    end
    max_s  = {sign_r, {(P-1){1'b1}}, 1'b0, {F{1'b1}}};
    zero_s = {sign_r, {(W-1){1'b0}}};
    case (kind_r)
      K_INV: begin
        p_nxt_s   = zero_s;
        oor_nxt_s = 4'b1000;
      end
      K_DBZ: begin
        p_nxt_s   = max_s;
        oor_nxt_s = 4'b0100;
      end
      K_ZERO: begin
        p_nxt_s   = zero_s;
        oor_nxt_s = 4'b0000;
      end
      K_NORM: begin
        if (e_fin_s >= E_MAX) begin
          p_nxt_s   = max_s;
          oor_nxt_s = 4'b0001;
        end else if (e_fin_s <= E_ZERO) begin
          p_nxt_s   = zero_s;
          oor_nxt_s = 4'b0010;
        end else begin
          p_nxt_s   = {sign_r, e_fin_s[P-1:0], frac_s};
          oor_nxt_s = 4'b0000;
        end
      end
      default: begin
        p_nxt_s   = zero_s;
        oor_nxt_s = 4'b1000;
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sign_r  <= 1'b0;
      kind_r  <= K_NORM;
      mode_r  <= 2'b00;
      exp_r   <= E_ZERO;
      rem_r   <= {(Q+2){1'b0}};
      div_r   <= {Q{1'b0}};
      quo_r   <= {(Q+1){1'b0}};
      cnt_r   <= {CW{1'b0}};
      p_r     <= {W{1'b0}};
      oor_r   <= 4'b0000;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          valid_r <= 1'b0;
          if (start_in) begin
            sign_r  <= x_in[W-1] ^ y_in[W-1];
            kind_r  <= kind_s;
            mode_r  <= round_in;
            div_r   <= my_s;
            quo_r   <= {(Q+1){1'b0}};
            cnt_r   <= CW'(Q + 1);
            ready_r <= 1'b0;
            // Pre-scale so the quotient lands in [1,2)
            if (mx_s < my_s) begin
              rem_r <= {1'b0, mx_s, 1'b0};
              exp_r <= e_raw_s - E_ONE;
            end else begin
              rem_r <= {2'b00, mx_s};
              exp_r <= e_raw_s;
            end
          end
        end
        DIV: begin
          rem_r <= rem_nxt_s;
          quo_r <= {quo_r[Q-1:0], qbit_s};
          cnt_r <= cnt_r - CW'(1);
        end
        ROUND: begin
          p_r     <= p_nxt_s;
          oor_r   <= oor_nxt_s;
          valid_r <= 1'b1;
          ready_r <= 1'b1;
        end
        default: begin
          valid_r <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign p_out     = p_r;
  assign oor_out   = oor_r;
  assign valid_out = valid_r;
  assign ready_out = ready_r;

endmodule

// File: tb/tb_fpdiv.sv
module tb_fpdiv;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [15:0] x_in = 16'h0000;
  logic [15:0] y_in = 16'h0000;
  logic [1:0]  round_in = 2'b00;
  logic        start_in = 1'b0;
  logic [15:0] p_out;
  logic [3:0]  oor_out;
  logic        valid_out;
  logic        ready_out;

  fpdiv #(.P(8), .Q(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .round_in(round_in), .start_in(start_in), .p_out(p_out),
    .oor_out(oor_out), .valid_out(valid_out), .ready_out(ready_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [15:0] p;
    logic [3:0]  oor;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest expectation
  always @(negedge clk_in) begin
    if (valid_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("p_out", {16'h0, p_out}, {16'h0, mon_e.p});
        check_eq("oor_out", {28'h0, oor_out}, {28'h0, mon_e.oor});
        check_eq("latency", cyc - mon_e.acc, 32'd10);
        check_eq("ready_at_valid", {31'h0, ready_out}, 32'd1);
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk_in);
      n++;
    end
    check_eq("drain_timeout", sb_q.size(), 32'd0);
    sb_q.delete();
  endtask

  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic [1:0] rnd,
                       input logic [15:0] ep, input logic [3:0] eo, input bit disturb);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk_in);
    while (ready_out !== 1'b1 && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 50) check_eq("ready_timeout", 32'd0, 32'd1);
    x_in = x; y_in = y; round_in = rnd; start_in = 1'b1;
    e.p = ep; e.oor = eo; e.acc = cyc + 1;
    sb_q.push_back(e);
    @(negedge clk_in);
    start_in = 1'b0;
    if (disturb) begin
      // New operands after accept, plus a start pulse in the middle of DIV
      x_in = 16'h4000; y_in = 16'h3F80; round_in = 2'b01;
      repeat (3) @(negedge clk_in);
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
    end
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check_eq("rst_ready", {31'h0, ready_out}, 32'd1);
    check_eq("rst_valid", {31'h0, valid_out}, 32'd0);
    check_eq("rst_p", {16'h0, p_out}, 32'h0);
    check_eq("rst_oor", {28'h0, oor_out}, 32'h0);
    rst_in = 1'b0;

    // Exact results
    do_op(16'h3F80, 16'h3F80, 2'b00, 16'h3F80, 4'b0000, 1'b0);
    do_op(16'h40C0, 16'h4000, 2'b00, 16'h4040, 4'b0000, 1'b0);

    // Rounding of 1/3 and -1/3
    do_op(16'h3F80, 16'h4040, 2'b00, 16'h3EAB, 4'b0000, 1'b0);
    do_op(16'h3F80, 16'h4040, 2'b01, 16'h3EAA, 4'b0000, 1'b0);
    do_op(16'hBF80, 16'h4040, 2'b10, 16'hBEAA, 4'b0000, 1'b0);
    do_op(16'hBF80, 16'h4040, 2'b11, 16'hBEAB, 4'b0000, 1'b0);

    // Exceptions
    do_op(16'h3F80, 16'h0000, 2'b00, 16'h7F7F, 4'b0100, 1'b0);
    do_op(16'h0000, 16'h0000, 2'b00, 16'h0000, 4'b1000, 1'b0);
    do_op(16'h7F00, 16'h3E80, 2'b00, 16'h7F7F, 4'b0001, 1'b0);
    do_op(16'h0080, 16'h7E00, 2'b00, 16'h0000, 4'b0010, 1'b0);
    do_op(16'h7F80, 16'h3F80, 2'b00, 16'h0000, 4'b1000, 1'b0);
    do_op(16'h8000, 16'h3F80, 2'b00, 16'h8000, 4'b0000, 1'b0);

    // Operands changed after accept and start pulsed mid-DIV
    do_op(16'h3F80, 16'h4040, 2'b00, 16'h3EAB, 4'b0000, 1'b1);

    // Reset during DIV iteration 4 discards the operation
    @(negedge clk_in);
    x_in = 16'h3F80; y_in = 16'h4040; round_in = 2'b00; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    check_eq("busy_ready", {31'h0, ready_out}, 32'd0);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    check_eq("abort_ready", {31'h0, ready_out}, 32'd1);
    check_eq("abort_valid", {31'h0, valid_out}, 32'd0);
    repeat (15) @(negedge clk_in);
    do_op(16'h40C0, 16'h4000, 2'b00, 16'h4040, 4'b0000, 1'b0);

    // start_in held high: accepts every 11 cycles
    @(negedge clk_in);
    x_in = 16'h40C0; y_in = 16'h4000; round_in = 2'b00; start_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mon_e.p = 16'h4040; mon_e.oor = 4'b0000; mon_e.acc = cyc + 1 + 11 * i;
      sb_q.push_back(mon_e);
    end
    repeat (23) @(negedge clk_in);
    start_in = 1'b0;
    wait_drain();
    repeat (15) @(negedge clk_in);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpdiv.md
Name: fpdiv

Overview:
- Sequential floating-point divider; the inverse-operation companion to the team's shift-add fpmult.
- Computes p_out = x_in / y_in on the same sign/exponent/fraction word format, with the same start/ready/valid handshake and the same round_in and oor_out encodings.
- Mantissa quotient is produced by a multi-cycle restoring shift-subtract engine: one quotient bit per clock.
- Sits beside fpmult in the arithmetic datapath.

Parameters:
- P, 8: exponent field width; bias = 2^(P-1)-1 (127).
- Q, 8: significand width including hidden bit; stored fraction is Q-1 bits. Word width = P+Q: 1 sign + P exponent + Q-1 fraction.

Ports:
- clk_in  input  1  clock; all state changes on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- x_in  input  P+Q  dividend; bit P+Q-1 is the sign.
- y_in  input  P+Q  divisor; bit P+Q-1 is the sign.
- round_in  input  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
- start_in  input  1  request; accepted only on an edge where ready_out=1.
- p_out  output  P+Q  quotient; held until the next result.
- oor_out  output  4  [0] overflow, [1] underflow, [2] divide-by-zero, [3] invalid (0/0 or exponent field all-ones on either input).
- valid_out  output  1  one-cycle pulse; p_out and oor_out are new this cycle.
- ready_out  output  1  idle; able to accept start_in.

Behaviour:
- Reset: on any edge with rst_in=1, regardless of state:
  - state <= IDLE, p_out <= 0, oor_out <= 0, valid_out <= 0, ready_out <= 1.
  - Any in-flight division is discarded; no valid_out is produced for it.
- Operand handling:
  - x_in, y_in and round_in are sampled once at the accept edge; later changes are ignored.
  - start_in while busy is ignored; it is not queued.
- Zero and subnormal inputs: an exponent field of 0 means zero; the fraction is ignored (subnormals flush to zero).
- States:
  - IDLE: ready_out=1. On start_in=1, capture operands and go to DIV; ready_out <= 0.
  - DIV: Q+1 iterations (9 by default). Each iteration: if remainder >= divisor, subtract and shift in 1, else shift in 0; remainder <<= 1. Counter decrements.
  - ROUND: one cycle. Normalize, round, check range, write p_out/oor_out, valid_out <= 1, ready_out <= 1, next state IDLE.
- Latency: accept at edge k; valid_out and ready_out are high after edge k+Q+2 (k+10 by default) for exactly one cycle. The earliest next accept is edge k+Q+3.
- Special cases still take full latency:
  - 0/0 or any exponent-all-ones input: p_out = {sign,0}, oor=1000.
  - nonzero/0: p_out = {sign, 2^P-2, all-ones fraction} (max finite), oor=0100.
  - 0/nonzero: signed zero, oor=0000.
- Arithmetic:
  - sign = xs ^ ys.
  - Exponent: e = ex - ey + bias, signed, P+2 bits.
  - If mx < my, dividend = mx<<1 and e = e-1, so the quotient lies in [1,2).
  - Result bits: Q quotient bits, guard = last quotient bit, sticky = (final remainder != 0).
  - Rounding increment:
    - RNE: guard & (sticky | lsb).
    - RZ: 0.
    - +inf: ~sign & (guard|sticky).
    - -inf: sign & (guard|sticky).
  - Rounding carry-out (significand = 2.0): fraction = 0, e = e+1.
- Range, checked after rounding:
  - e >= 2^P-1: p_out = signed max finite, oor=0001.
  - e <= 0: p_out = signed zero, oor=0010.
  - Otherwise oor=0000.

Test Plan:
- Reset: rst_in=1 for 2 cycles -> ready_out=1, valid_out=0, p_out=0x0000, oor_out=0. Assert rst_in at DIV iteration 4 -> no valid_out pulse, ready_out=1 next cycle, and a new start is accepted afterward.
- Exact results, round_in=00: 0x3F80/0x3F80 -> 0x3F80; 0x40C0/0x4000 (6/2) -> 0x4040. Each with valid_out exactly 10 cycles after accept and oor_out=0.
- Rounding, 1/3 (0x3F80/0x4040):
  - round_in=00 -> 0x3EAB.
  - round_in=01 -> 0x3EAA.
- Rounding, -1/3 (0xBF80/0x4040):
  - round_in=10 -> 0xBEAA.
  - round_in=11 -> 0xBEAB.
- Exceptions:
  - 0x3F80/0x0000 -> 0x7F7F, oor=0100.
  - 0x0000/0x0000 -> 0x0000, oor=1000.
  - 0x7F00/0x3E80 -> 0x7F7F, oor=0001.
  - 0x0080/0x7E00 -> 0x0000, oor=0010.
- Handshake:
  - start_in held high continuously -> accepts only when ready_out=1; results arrive every 11 cycles.
  - start_in pulsed mid-DIV -> ignored; operands changed after accept -> result unchanged.
